// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit shared definitions: size codes, FSM states.
// Misalignment helper is used when ALIGN_CHECK_EN is defined.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // reserved size 2'b11 is checked like a word
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    if (size == SZ_B) return 1'b0;
    if (size == SZ_H) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mau_lane: little-endian lane extract/extend for loads
// and lane merge of store data into a read word.
module mau_lane
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  // select lane, extend for loads, splice in store data
  always_comb begin
    b        = word[{off, 3'b000} +: 8];
    h        = word[{off[1], 4'b0000} +: 16];
    load_ext = word;
    merged   = wdata;
    case (size)
      SZ_B: begin
        load_ext = {{24{~uns & b[7]}}, b};
        merged   = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_ext = {{16{~uns & h[15]}}, h};
        merged   = word;
        merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_ext = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store front end onto a word-only memory port.
// Define ALIGN_CHECK_EN to flag misaligned half/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [AW+1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ack,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_wr,
  input  logic [DW-1:0] dm_dout
);

  state_t        state;
  logic [AW+1:0] addr_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rbuf;
  logic [DW-1:0] lane_word;
  logic [DW-1:0] load_ext;
  logic [DW-1:0] merged;
  logic          mis;

`ifdef ALIGN_CHECK_EN
  assign mis = misaligned(size, addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign busy    = (state != S_IDLE);
  assign dm_wr   = (state == S_WR);
  assign dm_addr = addr_q[AW+1:2];
  assign dm_din  = merged;

  // live memory word while reading, buffered word for the merge
  assign lane_word = (state == S_RD) ? dm_dout : rbuf;

  mau_lane u_lane (
    .word     (lane_word),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .load_ext (load_ext),
    .merged   (merged)
  );

  // access FSM, capture registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rbuf    <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            wdata_q <= wdata;
            if (mis) begin
              state <= S_ACK;
              ack   <= 1'b1;
              err   <= 1'b1;
            end else if (we && size[1]) begin
              state <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          rbuf <= dm_dout;
          if (we_q) begin
            state <= S_WR;
          end else begin
            rdata <= load_ext;
            state <= S_ACK;
            ack   <= 1'b1;
          end
        end
        S_WR: begin
          state <= S_ACK;
          ack   <= 1'b1;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a word memory model.
// Honours ALIGN_CHECK_EN when defined for the build.
module tb_mem_access_unit;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          uns;
  logic [AW+1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          busy;
  logic          err;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic          dm_wr;
  logic [31:0]   dm_dout;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] ref_rdata;
  logic [31:0] exp_q   [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(AW), .DW(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .size    (size),
    .uns     (uns),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ack     (ack),
    .busy    (busy),
    .err     (err),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_wr   (dm_wr),
    .dm_dout (dm_dout)
  );

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (dm_wr) begin
      mem[dm_addr] <= dm_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] w,
    input logic [1:0] off, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    int sh;
    sh = (sz == 2'b00) ? 8 * int'(off) :
         (sz == 2'b01) ? 16 * int'(off[1]) : 0;
    v = w >> sh;
    if (sz == 2'b00) return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (sz == 2'b01) return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] mdl_merge(input logic [31:0] w,
    input logic [1:0] off, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    sh = (sz == 2'b00) ? 8 * int'(off) :
         (sz == 2'b01) ? 16 * int'(off[1]) : 0;
    m = (sz == 2'b00) ? 32'h0000_00FF :
        (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  task automatic do_op(input string tag, input logic w,
    input logic [1:0] sz, input logic u, input logic [11:0] a,
    input logic [31:0] wd);
    logic        mis;
    logic [31:0] nw;
    logic [31:0] din;
    logic [31:0] e;
    int lat, cyc, wrs;
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    if (sz == 2'b01) mis = a[0];
    else if (sz != 2'b00) mis = (a[1:0] != 2'b00);
`endif
    nw = mdl_merge(ref_mem[a[11:2]], a[1:0], sz, wd);
    if (!mis) begin
      if (w) ref_mem[a[11:2]] = nw;
      else ref_rdata = mdl_load(ref_mem[a[11:2]], a[1:0], sz, u);
    end
    exp_q.push_back(ref_rdata);
    lat = mis ? 1 : (w && !sz[1]) ? 3 : 2;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = 12'($urandom); wdata = $urandom;
    cyc = 1; wrs = 0; din = '0;
    forever begin
      if (dm_wr) begin
        wrs++;
        din = dm_din;
      end
      if (ack || cyc >= 20) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, lat);
    chk({tag, ".wrs"}, wrs, (w && !mis) ? 1 : 0);
    chk({tag, ".err"}, {31'h0, err}, {31'h0, mis});
    if (w && !mis) chk({tag, ".din"}, din, nw);
    e = exp_q.pop_front();
    chk({tag, ".rdata"}, rdata, e);
    @(posedge clk); #1;
    chk({tag, ".mem"}, mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  initial begin
    int acks, idle, cyc;
    logic seen;
    logic [31:0] e;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    ref_rdata = '0;
    rst = 1'b1; clr = 1'b1; req = 1'b0; we = 1'b0;
    size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    #2;
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.ack", {31'h0, ack}, 32'h0);
    chk("rst.err", {31'h0, err}, 32'h0);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.dm_wr", {31'h0, dm_wr}, 32'h0);
    @(posedge clk); #1;
    clr = 1'b0; rst = 1'b0;

    // reset in the middle of a word store
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 12'h010;
    wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("t1.wr_on", {31'h0, dm_wr}, 32'h1);
    rst = 1'b1; #1;
    chk("t1.wr_off", {31'h0, dm_wr}, 32'h0);
    chk("t1.busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t1.mem", mem[4], 32'h0);
    chk("t1.rdata", rdata, 32'h0);

    do_op("t2.sw", 1'b1, 2'b10, 1'b0, 12'h010, 32'h1234_5678);
    do_op("t2.lw", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    chk("t2.val", rdata, 32'h1234_5678);

    do_op("t3.sb", 1'b1, 2'b00, 1'b0, 12'h011, 32'h5555_55AB);
    chk("t3.val", mem[4], 32'h1234_AB78);
    chk("t3.rdata", rdata, 32'h1234_5678);

    do_op("t4.sw", 1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF_7F01);
    do_op("t4.lb", 1'b0, 2'b00, 1'b0, 12'h012, 32'h0);
    chk("t4.lb.val", rdata, 32'hFFFF_FFFF);
    do_op("t4.lbu", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    chk("t4.lbu.val", rdata, 32'h0000_0080);
    do_op("t4.lh", 1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    chk("t4.lh.val", rdata, 32'hFFFF_80FF);
    do_op("t4.lhu", 1'b0, 2'b01, 1'b1, 12'h010, 32'h0);
    chk("t4.lhu.val", rdata, 32'h0000_7F01);

    do_op("t5.sh", 1'b1, 2'b01, 1'b0, 12'h011, 32'h0000_BEEF);
`ifdef ALIGN_CHECK_EN
    chk("t5.val", mem[4], 32'h80FF_7F01);
`else
    chk("t5.val", mem[4], 32'h80FF_BEEF);
`endif

    // three loads with req held high the whole time
    ref_rdata = ref_mem[4];
    repeat (3) exp_q.push_back(ref_rdata);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 12'h010;
    acks = 0; idle = 0; cyc = 0; seen = 1'b0;
    while (acks < 3 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) seen = 1'b1;
      else if (seen) idle++;
      if (ack) begin
        acks++;
        e = exp_q.pop_front();
        chk("t6.rdata", rdata, e);
      end
    end
    req = 1'b0;
    exp_q.delete();
    chk("t6.acks", acks, 3);
    chk("t6.gaps", idle, 2);
    @(posedge clk); #1;
    chk("t6.idle", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
